phivers_noc_injector: RTL and testbench

Parametrised multi-channel packet injector feeding a single NoC local port of the Phivers many-core. It is the synthesizable successor to the per-source injection path. It accepts flits from N_CHANNELS independent credit-based sources, buffers each channel in its own FIFO, and arbitrates whole Hermes-style packets (header, size, payload) onto one credit-based output. Typical use: sits between the MA/application sources and the manycore injection ports, so several streams share one port without interleaving flits.

---
 rtl/phivers_noc_injector_pkg.sv | 29 ++
 rtl/phivers_inj_fifo.sv | 73 +++++++
 rtl/phivers_noc_injector.sv | 199 +++++++++++++++++++
 tb/tb_phivers_noc_injector.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phivers_noc_injector_pkg.sv
// -----------------------------------------------------------------------------
// phivers_noc_injector_pkg
//   Shared types and constants for the Phivers NoC packet injector.
//   - inj_state_e : packet FSM state (IDLE, HEADER, SIZE, PAYLOAD)
//   - HDR_FLIT_IDX / SIZE_FLIT_IDX : position of the header and size flits
//     inside a Hermes-style packet (payload follows at SIZE_FLIT_IDX+1)
//   - inj_dbg_t : compact view of the packet FSM, for probes and checkers
// -----------------------------------------------------------------------------
package phivers_noc_injector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } inj_state_e;

  localparam int HDR_FLIT_IDX  = 0;
  localparam int SIZE_FLIT_IDX = 1;

  // Snapshot of the packet FSM: current state plus whether a flit moves
  // this cycle and whether the granted FIFO has run dry mid-packet.
  typedef struct packed {
    inj_state_e state;
    logic       xfer;
    logic       starved;
  } inj_dbg_t;

endpackage

// File: rtl/phivers_inj_fifo.sv
// -----------------------------------------------------------------------------
// phivers_inj_fifo
//   Per-channel first-word-fall-through FIFO with registered storage.
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   without a separate occupancy counter.
//
// Parameters
//   FLIT_SIZE    : flit width in bits
//   BUFFER_DEPTH : number of entries, power of two, >= 2
//
// Ports
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, empties the FIFO
//   push   : write request; ignored while full
//   data   : flit to write
//   pop    : read request; ignored while empty
//   full   : no free entry
//   empty  : no valid entry
//   head   : oldest flit (valid when !empty, zero after reset)
// -----------------------------------------------------------------------------
module phivers_inj_fifo #(
  parameter int FLIT_SIZE    = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push,
  input  logic [FLIT_SIZE-1:0] data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [FLIT_SIZE-1:0] head
);

  localparam int AW = $clog2(BUFFER_DEPTH);

  logic [FLIT_SIZE-1:0] mem [BUFFER_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot, opposite lap: the writer is a full buffer ahead of the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Gating pop with empty makes push+pop on an empty FIFO behave as a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Clearing storage keeps head (and hence data_o) at zero out of reset.
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/phivers_noc_injector.sv
// -----------------------------------------------------------------------------
// phivers_noc_injector
//   Multi-channel packet injector for one Phivers NoC local port. Each source
//   channel is buffered in its own phivers_inj_fifo; whole packets
//   (header, size S, S payload flits) are arbitrated onto a single
//   credit-based output without interleaving flits of different channels.
//
// Build option
//   PHIVERS_INJ_PRIO_EN : when defined, the lowest non-empty channel index
//                         wins (fixed priority, no last_grant register).
//                         When undefined, round robin starting after the
//                         previously granted channel. Ports are identical.
//
// Parameters
//   N_CHANNELS   : number of source channels, >= 1
//   FLIT_SIZE    : flit width in bits
//   BUFFER_DEPTH : per-channel FIFO depth, power of two, >= 2
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   src_rx_i     : per-channel flit valid
//   src_credit_o : per-channel space available (FIFO not full)
//   src_data_i   : per-channel flits, [N_CHANNELS-1:0][FLIT_SIZE-1:0]
//   tx_o         : output flit valid
//   credit_i     : downstream accepts a flit this cycle
//   data_o       : output flit
//   channel_o    : currently granted channel
//   busy_o       : a packet is in progress (FSM not in IDLE)
//
// Handshake: a source flit moves when src_rx_i[c] && src_credit_o[c]; an
// output flit moves (and pops its FIFO) when tx_o && credit_i. Neither valid
// depends combinationally on its own ready, and data_o / src_credit_o come
// only from registered FIFO and grant state.
// -----------------------------------------------------------------------------
module phivers_noc_injector
  import phivers_noc_injector_pkg::*;
#(
  parameter  int N_CHANNELS   = 2,
  parameter  int FLIT_SIZE    = 32,
  parameter  int BUFFER_DEPTH = 8,
  localparam int CW           = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [N_CHANNELS-1:0]                src_rx_i,
  output logic [N_CHANNELS-1:0]                src_credit_o,
  input  logic [N_CHANNELS-1:0][FLIT_SIZE-1:0] src_data_i,
  output logic                                 tx_o,
  input  logic                                 credit_i,
  output logic [FLIT_SIZE-1:0]                 data_o,
  output logic [CW-1:0]                        channel_o,
  output logic                                 busy_o
);

  // ---------------------------------------------------------------------------
  // Per-channel buffering
  // ---------------------------------------------------------------------------
  logic [N_CHANNELS-1:0]                full;
  logic [N_CHANNELS-1:0]                empty;
  logic [N_CHANNELS-1:0]                pop;
  logic [N_CHANNELS-1:0][FLIT_SIZE-1:0] head;

  inj_state_e           state;
  logic [CW-1:0]        grant;
  logic [FLIT_SIZE-1:0] count;
  logic [CW-1:0]        winner;
  logic                 any_ready;
  logic                 xfer;
  logic [FLIT_SIZE-1:0] head_sel;
  inj_dbg_t             dbg;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
    phivers_inj_fifo #(
      .FLIT_SIZE    (FLIT_SIZE),
      .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (src_rx_i[g]),
      .data   (src_data_i[g]),
      .pop    (pop[g]),
      .full   (full[g]),
      .empty  (empty[g]),
      .head   (head[g])
    );

    // Only the granted FIFO is ever drained.
    assign pop[g] = xfer && (grant == CW'(g));
  end

  assign src_credit_o = ~full;

  // ---------------------------------------------------------------------------
  // Output path
  // ---------------------------------------------------------------------------
  assign head_sel  = head[grant];
  assign data_o    = head_sel;
  // A starved granted channel just drops tx_o; the grant is kept.
  assign tx_o      = (state != IDLE) && !empty[grant];
  assign xfer      = tx_o && credit_i;
  assign channel_o = grant;
  assign busy_o    = (state != IDLE);
  assign any_ready = |(~empty);

  assign dbg.state   = state;
  assign dbg.xfer    = xfer;
  assign dbg.starved = (state != IDLE) && empty[grant];

  // ---------------------------------------------------------------------------
  // Arbitration (evaluated only while IDLE)
  // ---------------------------------------------------------------------------
`ifdef PHIVERS_INJ_PRIO_EN

  always_comb begin
    winner = '0;
    // Walking down lets the lowest non-empty index overwrite the others.
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        winner = CW'(i);
      end
    end
  end

`else

  logic [CW-1:0] last_grant;

  always_comb begin
    int d;
    int best_d;
    winner = last_grant;
    best_d = N_CHANNELS;
    d      = 0;
    // d is the distance of channel i from the slot just after last_grant,
    // so the nearest non-empty channel in wrap-around order wins.
    for (int i = 0; i < N_CHANNELS; i++) begin
      d = (i + N_CHANNELS - 1 - int'(last_grant)) % N_CHANNELS;
      if (!empty[i] && (d < best_d)) begin
        best_d = d;
        winner = CW'(i);
      end
    end
  end

`endif

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      grant <= '0;
      count <= '0;
`ifndef PHIVERS_INJ_PRIO_EN
      // Pointing at the last channel makes channel 0 the first winner.
      last_grant <= CW'(N_CHANNELS - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_ready) begin
            grant <= winner;
`ifndef PHIVERS_INJ_PRIO_EN
            last_grant <= winner;
`endif
            state <= HEADER;
          end
        end

        HEADER: begin
          if (xfer) begin
            state <= SIZE;
          end
        end

        SIZE: begin
          if (xfer) begin
            count <= head_sel;
            state <= (head_sel == '0) ? IDLE : PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (xfer) begin
            count <= count - 1'b1;
            if (count == FLIT_SIZE'(1)) begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phivers_noc_injector.sv
// -----------------------------------------------------------------------------
// tb_phivers_noc_injector
//   Self-checking bench for phivers_noc_injector (N_CHANNELS=2, FLIT_SIZE=32,
//   BUFFER_DEPTH=8). Sources push flits into per-channel expected queues as
//   they are accepted; a monitor parses the output stream into packets and
//   checks flit data, per-channel ordering, packet atomicity and (where a
//   test sets it) the expected packet grant order.
// -----------------------------------------------------------------------------
module tb_phivers_noc_injector;

  localparam int N = 2;
  localparam int W = 32;
  localparam int D = 8;
  localparam int BOUND = 3000;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           src_rx_a [N];
  logic [W-1:0]   src_dat_a [N];
  logic [N-1:0]   src_rx_i;
  logic [N-1:0][W-1:0] src_data_i;
  logic [N-1:0]   src_credit_o;
  logic           tx_o;
  logic           credit_i;
  logic [W-1:0]   data_o;
  logic [0:0]     channel_o;
  logic           busy_o;

  always_comb begin
    src_rx_i   = '0;
    src_data_i = '0;
    for (int c = 0; c < N; c++) begin
      src_rx_i[c]   = src_rx_a[c];
      src_data_i[c] = src_dat_a[c];
    end
  end

  phivers_noc_injector #(
    .N_CHANNELS   (N),
    .FLIT_SIZE    (W),
    .BUFFER_DEPTH (D)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .src_rx_i     (src_rx_i),
    .src_credit_o (src_credit_o),
    .src_data_i   (src_data_i),
    .tx_o         (tx_o),
    .credit_i     (credit_i),
    .data_o       (data_o),
    .channel_o    (channel_o),
    .busy_o       (busy_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int           vectors = 0;
  int           miscompares = 0;
  int           cycle = 0;
  logic [W-1:0] exp_q [N][$];
  int           exp_ch_q [$];
  int           xfer_t [$];
  logic         rand_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound of %0d cycles expired (cycle %0d)", name, BOUND, cycle);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples after inputs settle, before the next rising edge.
  // ---------------------------------------------------------------------------
  initial begin
    int           pos;
    int           pkt_ch;
    int           ch;
    logic [W-1:0] rem;
    pos = 0;
    pkt_ch = 0;
    rem = '0;
    forever begin
      @(negedge clk_i);
      #2;
      cycle++;
      if (!rst_ni) begin
        pos = 0;
      end else if (tx_o && credit_i) begin
        ch = int'(channel_o);
        xfer_t.push_back(cycle);
        if (pos == 0) begin
          pkt_ch = ch;
          if (exp_ch_q.size() > 0) check("grant_order", 64'(ch), 64'(exp_ch_q.pop_front()));
        end else begin
          check("no_interleave", 64'(ch), 64'(pkt_ch));
        end
        if (exp_q[ch].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_flit: got 0x%0h on ch%0d, expected none (cycle %0d)",
                   data_o, ch, cycle);
        end else begin
          check("flit_data", 64'(data_o), 64'(exp_q[ch].pop_front()));
        end
        // Packet framing from the format: header, size S, then S payload flits.
        if (pos == 0) begin
          pos = 1;
        end else if (pos == 1) begin
          rem = data_o;
          pos = (rem == '0) ? 0 : 2;
        end else begin
          rem = rem - 1;
          if (rem == '0) pos = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_flit(input int c, input logic [W-1:0] d);
    int t;
    t = 0;
    src_rx_a[c]  = 1'b1;
    src_dat_a[c] = d;
    while (!src_credit_o[c] && t < BOUND) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= BOUND) begin
      fail($sformatf("send_ch%0d", c));
      src_rx_a[c] = 1'b0;
      return;
    end
    exp_q[c].push_back(d);
    @(negedge clk_i);
    src_rx_a[c] = 1'b0;
  endtask

  task automatic send_packet(input int c, input logic [W-1:0] hdr, input int size);
    send_flit(c, hdr);
    send_flit(c, W'(size));
    for (int i = 0; i < size; i++) send_flit(c, $urandom);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy_o) && t < BOUND) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= BOUND) fail("drain");
    repeat (2) @(negedge clk_i);
    check("drain_busy", 64'(busy_o), 64'(0));
    check("drain_left", 64'(exp_q[0].size() + exp_q[1].size()), 64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int c = 0; c < N; c++) begin
      src_rx_a[c]  = 1'b0;
      src_dat_a[c] = '0;
    end
    credit_i = 1'b0;
    rst_ni   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk_i);
    check("rst_tx", 64'(tx_o), 64'(0));
    check("rst_data", 64'(data_o), 64'(0));
    check("rst_channel", 64'(channel_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_credit", 64'(src_credit_o), 64'(2'b11));
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Contention: both channels queue two size-1 packets at the same edges.
`ifdef PHIVERS_INJ_PRIO_EN
    exp_ch_q = '{0, 0, 1, 1};
`else
    exp_ch_q = '{0, 1, 0, 1};
`endif
    fork
      begin send_packet(0, 32'h0000_0A01, 1); send_packet(0, 32'h0000_0A02, 1); end
      begin send_packet(1, 32'h0000_0B01, 1); send_packet(1, 32'h0000_0B02, 1); end
    join
    credit_i = 1'b1;
    wait_drain();
    check("contention_order_done", 64'(exp_ch_q.size()), 64'(0));

    // Single packet, preloaded, then streamed at full rate.
    credit_i = 1'b0;
    send_flit(0, 32'h0101);
    send_flit(0, 32'd3);
    send_flit(0, 32'hA);
    send_flit(0, 32'hB);
    send_flit(0, 32'hC);
    xfer_t.delete();
    credit_i = 1'b1;
    wait_drain();
    check("single_count", 64'(xfer_t.size()), 64'(5));
    if (xfer_t.size() == 5) check("single_back_to_back", 64'(xfer_t[4] - xfer_t[0]), 64'(4));
    check("single_channel", 64'(channel_o), 64'(0));

    // Zero-size packets: exactly one idle bubble between packets.
    credit_i = 1'b0;
    send_flit(0, 32'h0202);
    send_flit(0, 32'd0);
    send_flit(0, 32'h0303);
    send_flit(0, 32'd0);
    xfer_t.delete();
    credit_i = 1'b1;
    wait_drain();
    check("zero_count", 64'(xfer_t.size()), 64'(4));
    if (xfer_t.size() == 4) begin
      check("zero_hdr_to_size", 64'(xfer_t[1] - xfer_t[0]), 64'(1));
      check("zero_bubble", 64'(xfer_t[2] - xfer_t[1]), 64'(2));
      check("zero_second_pkt", 64'(xfer_t[3] - xfer_t[2]), 64'(1));
    end

    // Backpressure: fill ch1 (8 flits), 9th flit must be held.
    credit_i = 1'b0;
    send_flit(1, 32'h1111);
    send_flit(1, 32'd7);
    for (int i = 0; i < 6; i++) send_flit(1, 32'h1100 + 32'(i));
    check("full_credit_ch1", 64'(src_credit_o[1]), 64'(0));
    check("full_credit_ch0", 64'(src_credit_o[0]), 64'(1));
    fork
      send_flit(1, 32'h11FF);
      begin
        repeat (3) @(negedge clk_i);
        check("held_credit_ch1", 64'(src_credit_o[1]), 64'(0));
        check("held_tx", 64'(tx_o), 64'(1));
        check("held_ch1_pending", 64'(exp_q[1].size()), 64'(8));
        credit_i = 1'b1;
      end
    join
    wait_drain();

    // Randomized traffic with random downstream credit.
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(negedge clk_i);
          credit_i = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    fork
      for (int p = 0; p < 5; p++) send_packet(0, $urandom, int'($urandom_range(0, 5)));
      for (int p = 0; p < 5; p++) send_packet(1, $urandom, int'($urandom_range(0, 5)));
    join
    rand_on = 1'b0;
    repeat (2) @(negedge clk_i);
    credit_i = 1'b1;
    wait_drain();

    // Source starvation: ch0 stalls mid-packet, ch1 must wait.
    exp_ch_q = '{0, 1};
    send_flit(0, 32'h0404);
    send_flit(0, 32'd4);
    send_flit(0, 32'h0441);
    send_flit(0, 32'h0442);
    send_packet(1, 32'h0505, 2);
    repeat (4) @(negedge clk_i);
    check("starve_tx", 64'(tx_o), 64'(0));
    check("starve_channel", 64'(channel_o), 64'(0));
    check("starve_busy", 64'(busy_o), 64'(1));
    send_flit(0, 32'h0443);
    send_flit(0, 32'h0444);
    wait_drain();
    check("starve_order_done", 64'(exp_ch_q.size()), 64'(0));

    // Reset in the middle of a payload.
    send_flit(0, 32'h0606);
    send_flit(0, 32'd6);
    send_flit(0, 32'h0661);
    send_flit(0, 32'h0662);
    send_packet(1, 32'h0707, 1);
    repeat (3) @(negedge clk_i);
    check("pre_rst_busy", 64'(busy_o), 64'(1));
    rst_ni = 1'b0;
    #1;
    check("midrst_tx", 64'(tx_o), 64'(0));
    check("midrst_data", 64'(data_o), 64'(0));
    check("midrst_channel", 64'(channel_o), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_credit", 64'(src_credit_o), 64'(2'b11));
    for (int c = 0; c < N; c++) exp_q[c].delete();
    exp_ch_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    exp_ch_q = '{0};
    send_packet(0, 32'h0808, 2);
    wait_drain();
    check("post_rst_order_done", 64'(exp_ch_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog in case a driver or wait loop never returns.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

endmodule
